// File: rtl/dsp_ctl_pkg.sv
// Shared definitions for the DSP48A1-style slice controller and its wrapper.
// Holds the sequencer state encoding and the OPMODE codes (DSP48A1 encoding)
// that the sequencer issues to the slice.
package dsp_ctl_pkg;

    typedef enum logic [1:0] {
        DSP_IDLE  = 2'd0,
        DSP_FEED  = 2'd1,
        DSP_DRAIN = 2'd2,
        DSP_DONE  = 2'd3
    } dsp_state_e;

    localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0   : P = M
    localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P   : P = P + M
    localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P   : P holds
    localparam logic [7:0] OPM_IDLE  = 8'h00;

endpackage

// File: rtl/dsp_ctl_dly.sv
// Fixed-depth shift register used to align per-sample tags with the slice
// pipeline. A new value (load_val) enters every cycle; dout is the value that
// entered DEPTH cycles earlier. All stages clear to zero on reset.
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   load_val in  value shifted into the first stage
//   dout     out last stage
module dsp_ctl_dly #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = load_val;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer for one DSP48A1-style MAC slice. Accepts len operand
// pairs over a valid/ready handshake, gates the slice clock enables, issues
// pipeline-aligned OPMODE codes (first product loads P, later ones accumulate)
// and pulses p_valid once the slice pipeline has drained.
//   CLK      in  clock
//   rst      in  asynchronous active-high reset
//   start    in  begin a job (sampled in IDLE only)
//   len      in  number of sample pairs, latched with start
//   in_valid in  operand pair present on slice A/B inputs
//   in_ready out sequencer accepts a pair this cycle
//   cea/ceb  out A/B register enables (= accept)
//   cem/cep  out M/P register enables (= busy)
//   opmode   out slice OPMODE
//   busy     out job in progress
//   p_valid  out slice P holds the completed sum (one cycle)
//   err      out start with len == 0 (one cycle)
//
// state | meaning
// IDLE  | waiting for start
// FEED  | accepting operand pairs until len have been taken
// DRAIN | pipeline flushing, no operands accepted
// DONE  | P holds the final sum, p_valid asserted
module dsp_mac_seq
    import dsp_ctl_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int OPM_DLY  = 2,
    parameter int PIPE_LAT = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             cea,
    output logic             ceb,
    output logic             cem,
    output logic             cep,
    output logic [7:0]       opmode,
    output logic             busy,
    output logic             p_valid,
    output logic             err
);

    localparam logic [1:0] ST_IDLE  = DSP_IDLE;
    localparam logic [1:0] ST_FEED  = DSP_FEED;
    localparam logic [1:0] ST_DRAIN = DSP_DRAIN;
    localparam logic [1:0] ST_DONE  = DSP_DONE;

    // DRAIN lasts PIPE_LAT-1 cycles; the counter runs down to zero.
    localparam logic [3:0] DRN_INIT = (PIPE_LAT > 1) ? 4'(PIPE_LAT - 2) : 4'd0;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [3:0]       drn_q, drn_d;
    logic             err_q, err_d;
    logic             prev_done_q, prev_done_d;

    logic             accept;
    logic [7:0]       tag;
    logic [7:0]       dly_out;

    assign accept = (state_q == ST_FEED) && in_valid;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        drn_d       = drn_q;
        err_d       = 1'b0;
        prev_done_d = (state_q == ST_DONE);
        tag         = OPM_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = len;
                        cnt_d   = '0;
                        first_d = 1'b1;
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                if (accept) begin
                    tag     = first_q ? OPM_FIRST : OPM_ACC;
                    first_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        // With a one-cycle pipeline there is nothing to drain.
                        if (PIPE_LAT == 1) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DRAIN;
                            drn_d   = DRN_INIT;
                        end
                    end
                end else begin
                    // Bubble: keep P, and first_q stays set for the real first sample.
                    tag = OPM_HOLD;
                end
            end
            ST_DRAIN: begin
                tag = OPM_HOLD;
                if (drn_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    drn_d = drn_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            drn_q       <= 4'd0;
            err_q       <= 1'b0;
            prev_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            drn_q       <= drn_d;
            err_q       <= err_d;
            prev_done_q <= prev_done_d;
        end
    end

    dsp_ctl_dly #(
        .WIDTH (8),
        .DEPTH (OPM_DLY)
    ) u_opm_dly (
        .clk      (CLK),
        .rst      (rst),
        .load_val (tag),
        .dout     (dly_out)
    );

    // P must not move once the sum is complete, so DONE and the IDLE cycle
    // right after it hold P regardless of what is left in the delay line.
    always_comb begin
        opmode = OPM_IDLE;
        case (state_q)
            ST_FEED, ST_DRAIN: opmode = dly_out;
            ST_DONE:           opmode = OPM_HOLD;
            default:           opmode = prev_done_q ? OPM_HOLD : OPM_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_FEED);
    assign cea      = accept;
    assign ceb      = accept;
    assign busy     = (state_q != ST_IDLE);
    assign cem      = busy;
    assign cep      = busy;
    assign p_valid  = (state_q == ST_DONE);
    assign err      = err_q;

endmodule
